// File: rtl/fetch_pkg.sv
// Shared widths, the halt encoding and the fetch-buffer entry type for the
// instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential successor; the 32-bit add wraps FFFF_FFFC to 0 on its own.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(INSTR_BYTES);
    endfunction

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over push and over the read-pointer advance from pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    fetch_entry_t     entry_reg [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) entry_reg[i] <= entry;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head = empty ? '0 : entry_reg[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, zero-latency memory read, halt-on-zero-word and
// redirect/flush control in front of a 2-entry fetch buffer.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              halted_reg, halted_next;
    logic [15:0]       fetch_count_reg, fetch_count_next;

    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;
    logic         pop;
    logic         fetch_en;
    logic         is_halt_word;
    logic         push;

    assign pop          = if_valid && if_ready;
    assign fetch_en     = !halted_reg && !redirect_valid && (!buf_full || pop);
    assign is_halt_word = (imem_instr == HALT_WORD);
    assign push         = fetch_en && !is_halt_word;
    assign push_entry   = '{pc: pc_reg, instr: imem_instr};

    always_comb begin
        pc_next          = pc_reg;
        halted_next      = halted_reg;
        fetch_count_next = fetch_count_reg;
        if (redirect_valid) begin
            pc_next     = align_pc(redirect_pc);
            halted_next = 1'b0;
        end else if (push) begin
            pc_next = next_pc(pc_reg);
            if (fetch_count_reg != 16'hFFFF) fetch_count_next = fetch_count_reg + 16'd1;
        end else if (fetch_en) begin
            // Zero word: PC parks on its address until a redirect or reset.
            halted_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            halted_reg      <= 1'b0;
            fetch_count_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            halted_reg      <= halted_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .entry (push_entry),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

    assign imem_addr   = pc_reg;
    assign if_valid    = !buf_empty;
    assign if_instr    = buf_head.instr;
    assign if_pc       = buf_head.pc;
    assign halted      = halted_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised and directed checks of instruction_fetch_unit against a queue-based
// model of the fetch rules; a second instance covers the top-of-memory wrap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] w_addr, w_instr, w_if_instr, w_if_pc;
    logic        w_if_valid, w_halted;
    logic [15:0] w_fetch_count;

    logic [31:0] mem [64];

    assign imem_instr = mem[imem_addr[7:2]];
    assign w_instr    = mem[w_addr[7:2]];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_instr(w_instr),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .if_valid(w_if_valid),
        .if_ready(1'b1), .if_instr(w_if_instr), .if_pc(w_if_pc),
        .halted(w_halted), .fetch_count(w_fetch_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of {pc, instr}.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_halted;
    int          m_fc;

    function automatic void model_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        m_fc     = 0;
    endfunction

    function automatic void model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
        int          n_before;
        logic        popped;
        logic [31:0] w;
        ent_t        e;
        n_before = m_q.size();
        popped   = (n_before > 0) && rdy;
        if (popped) void'(m_q.pop_front());
        if (rv) begin
            m_q.delete();
            m_pc     = rpc & 32'hFFFF_FFFC;
            m_halted = 1'b0;
        end else if (!m_halted && (n_before < 2 || popped)) begin
            w = mem[m_pc[7:2]];
            if (w == 32'h0) begin
                m_halted = 1'b1;
            end else begin
                e.pc = m_pc;
                e.instr = w;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
                if (m_fc < 65535) m_fc++;
            end
        end
    endfunction

    task automatic compare_outputs();
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_q.size() != 0});
        check("if_pc", if_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
        check("if_instr", if_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        check("fetch_count", {16'b0, fetch_count}, m_fc[31:0]);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        compare_outputs();
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(rdy, rv, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic pulse_reset();
        #2;
        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        model_reset();
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_fetch_count", {16'b0, fetch_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        mem[3] = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch of A, B, C then the zero word at 12.
        check("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check("first_valid", {31'b0, if_valid}, 32'h1);
        check("first_pc", if_pc, 32'h0);
        check("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
        check("wrap_if_instr", w_if_instr, mem[63]);
        check("wrap_addr", w_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("third_pc", if_pc, 32'h8);
        check("third_instr", if_instr, mem[2]);
        check("three_fetched", {16'b0, fetch_count}, 32'd3);
        step(1'b1, 1'b0, 32'h0);
        check("halt_set", {31'b0, halted}, 32'h1);
        check("halt_addr", imem_addr, 32'hC);
        check("drained", {31'b0, if_valid}, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);

        // Backpressure: buffer fills, PC freezes at 8, then drains in order.
        pulse_reset();
        repeat (5) step(1'b0, 1'b0, 32'h0);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_head", if_pc, 32'h0);
        repeat (5) step(1'b1, 1'b0, 32'h0);

        // Redirect while halted clears halt.
        step(1'b1, 1'b1, 32'h27);
        check("redir_halt_clear", {31'b0, halted}, 32'h0);
        check("redir_addr", imem_addr, 32'h24);

        // Redirect with two entries buffered and decode accepting.
        pulse_reset();
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h27);
        check("flush_addr", imem_addr, 32'h24);
        check("flush_empty", {31'b0, if_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("target_valid", {31'b0, if_valid}, 32'h1);
        check("target_pc", if_pc, 32'h24);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // Random traffic with sparse zero words, redirects and mid-stream resets.
        for (int r = 0; r < 4; r++) begin
            #2;
            rst_n = 1'b0;
            for (int i = 0; i < 64; i++)
                mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
            mem[0] = 32'h1234_5679;
            @(negedge clk);
            model_reset();
            rst_n = 1'b1;
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
            end
            // Fill the buffer, then reset mid-stream.
            step(1'b1, 1'b1, 32'h0);
            repeat (3) step(1'b0, 1'b0, 32'h0);
            pulse_reset();
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream stage of the instruction memory: owns the program counter, drives the memory read address, and captures each returned instruction word with its PC into a 2-entry fetch buffer. The fetch buffer feeds the decode stage through a valid/ready handshake. Supports control-flow redirect with buffer flush, and halts fetching on an all-zero instruction word.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `BUF_DEPTH`, default 2: fetch-buffer entries; fixed at 2 for this revision.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `imem_addr`, output, 32: byte address to instruction memory; equals the PC register.
- `imem_instr`, input, 32: instruction word returned combinationally for `imem_addr`.
- `redirect_valid`, input, 1: load a new PC and flush the buffer.
- `redirect_pc`, input, 32: target byte address; bits [1:0] are forced to 0.
- `if_valid`, output, 1: buffer head holds a valid instruction.
- `if_ready`, input, 1: decode accepts the head this cycle.
- `if_instr`, output, 32: head instruction word.
- `if_pc`, output, 32: PC of the head instruction.
- `halted`, output, 1: a zero word was fetched and fetching has stopped.
- `fetch_count`, output, 16: saturating count of words pushed into the buffer.

## Operation
- Registered state:
  - `pc`
  - buffer entries of {pc, instr}
  - read/write pointers
  - `count` (0..2)
  - `halted`
  - `fetch_count`
- Fetch condition, evaluated every cycle:
  - `fetch_en = !halted && !redirect_valid && (count < 2 || pop)`.
  - `pop = if_valid && if_ready`.
- When `fetch_en` holds and `imem_instr != 0`:
  - push {pc, imem_instr};
  - `pc <= pc + 4`, wrapping 32'hFFFF_FFFC to 0;
  - `fetch_count` increments, saturating at 16'hFFFF.
- When `fetch_en` holds and `imem_instr == 0`:
  - no push;
  - `halted <= 1`;
  - `pc` holds at the zero word's address.
- Head output:
  - `if_valid = (count != 0)`;
  - `if_instr` and `if_pc` come from the entry at the read pointer;
  - both read 0 when the buffer is empty.
- Redirect (highest priority):
  - `pc <= {redirect_pc[31:2], 2'b00}`;
  - `count <= 0` and pointers reset;
  - `halted <= 0`;
  - no push that cycle.
  - A pop in the same cycle is honoured: decode consumes the head, and the remaining entries are discarded.
- Simultaneous push and pop when full: allowed, `count` stays 2, FIFO order preserved.
- Pop when empty: impossible, since `if_valid` is 0.
- Halted with entries still buffered: the buffer keeps draining normally.

## Timing
- Reset values (asynchronous):
  - `pc = RESET_PC`, `count = 0`, `halted = 0`, `fetch_count = 0`;
  - `if_valid = 0`, `if_instr = 0`, `if_pc = 0`;
  - `imem_addr = RESET_PC`.
- Reset mid-operation: all state returns to reset values immediately; buffered entries are lost.
- `imem_addr` is a pure register output; `imem_instr` is sampled in the same cycle (zero-latency memory).
- Latency: after the first rising edge following reset release, `if_valid = 1` with `if_pc = RESET_PC`.
- Redirect: the edge in which `redirect_valid` is sampled loads the target. The target instruction is at the head (`if_valid = 1`) after the following edge, i.e. 2 cycles from redirect assertion to valid target.
- Steady state: 1 instruction per cycle while `if_ready` is held high.
- Backpressure: with `if_ready = 0`, the buffer fills in 2 cycles, then `pc` freezes until a pop.

## Structure
- Package `fetch_pkg` holds:
  - `INSTR_W = 32`, `ADDR_W = 32`;
  - `INSTR_BYTES = 4`;
  - `HALT_WORD = 32'h0000_0000`;
  - typedef `fetch_entry_t` = {pc, instr}.
- Sub-module `fetch_buffer`: parameterised 2-entry synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, full, empty, head.
  - `flush` has priority over `push` and over the pointer update from `pop`.
- Top level holds the PC register, fetch/halt control, the saturating counter, and the redirect mux.

## Test plan
- Reset release, memory words A, B, C at byte addresses 0, 4, 8, `if_ready = 1` → `if_pc` = 0, 4, 8 on consecutive cycles with matching `if_instr`; `fetch_count` = 3.
- `if_ready = 0` for 5 cycles → `count` reaches 2, `imem_addr` freezes at 8. Then release `if_ready` → A and B are emitted in order, then C, with no loss or duplication.
- Zero word at address 12 → 3 instructions emitted, `halted = 1` next cycle, `imem_addr` stays 12, `if_valid` drops after the buffer drains.
- `redirect_valid` with `redirect_pc = 32'h27` while 2 entries are buffered and `if_ready = 1` → head consumed, remaining entry flushed, `imem_addr = 32'h24`, next valid `if_pc = 32'h24`; `halted` also clears when the redirect arrives while halted.
- `rst_n` pulsed low mid-stream with a full buffer → outputs zero immediately, `imem_addr = RESET_PC`, and the fetch sequence restarts from `RESET_PC`.
- `RESET_PC = 32'hFFFF_FFFC` with a nonzero word there → `if_pc = 32'hFFFF_FFFC`, then `imem_addr` wraps to 0.
